serial_link_arbiter: RTL and testbench
======================================

// Module: serial_link_arbiter
// PURPOSE
//   Shares one serial_to_parallel deserializer among N_REQ serial sources.
//   Grants the serial channel to one requester per frame of WIDTH bits, using
//   round-robin arbitration. Forwards the granted source's bit stream and tags it
//   with the owner index. Aborts and flushes on a mid-frame request drop.
// PARAMETERS
//   N_REQ  4  number of serial requesters (>=2)
//   WIDTH  8  bits per frame; must equal the downstream deserializer width
// PORTS
//   clk        in   1                 clock
//   rst        in   1                 reset
//   req        in   N_REQ             per-source frame request; held high for the whole frame
//   bit_valid  in   N_REQ             per-source serial bit valid
//   bit_data   in   N_REQ             per-source serial bit
//   grant      out  N_REQ             one-hot grant, registered; all zero when idle
//   owner_id   out  $clog2(N_REQ)     index of the granted source; valid while busy
//   busy       out  1                 a frame is in progress (state BUSY)
//   ser_valid  out  1                 to deserializer serial_valid
//   ser_data   out  1                 to deserializer serial_data
//   ser_last   out  1                 pulses high with the WIDTH-th forwarded bit
//   ser_flush  out  1                 one-cycle pulse on abort; clears the deserializer
// BEHAVIOUR
//   Reset: rst is synchronous, active-high; clk is the clock. During and after reset:
//   - state=IDLE; grant=0, owner_id=0, busy=0, ser_*=0.
//   - Bit counter=0; RR pointer=0, so source 0 has highest priority first.
//   IDLE:
//   - If any req bit is high, pick the first req[i] scanning i = ptr, ptr+1, ..., mod N_REQ.
//   - Register grant[i]=1 and owner_id=i, then go to BUSY. Arbitration latency is 1 cycle.
//   - No bits are forwarded while in IDLE.
//   BUSY (granted source g):
//   - ser_valid = bit_valid[g] and ser_data = bit_data[g]. This path is combinational
//     from the inputs, with zero latency.
//   - ser_valid and ser_data are 0 outside BUSY.
//   - bit_valid and bit_data from non-granted sources are ignored (no buffering).
//   - Counter increments on each forwarded bit (ser_valid=1).
//   - The bit that brings the count to WIDTH asserts ser_last in the same cycle. On the
//     next edge: counter <- 0, ptr <- (g+1) mod N_REQ, grant <- 0, state <- IDLE.
//   - Between frames there is one idle cycle, even if requests are pending.
//   Abort: req[g]=0 while BUSY with count < WIDTH.
//   - That cycle: ser_valid is forced 0 and ser_flush=1. No bit is forwarded, even if
//     bit_valid[g]=1.
//   - Next edge: IDLE, counter <- 0, ptr <- (g+1) mod N_REQ.
//   - An abort with count=0 still pulses ser_flush.
//   Simultaneous events:
//   - If req[g] drops in the same cycle as the WIDTH-th bit, the frame completes:
//     ser_last=1 and no flush.
//   - New req from other sources during BUSY: held off; the arbiter does not preempt.
//   Reset mid-frame: drops grant, with no ser_flush pulse. The deserializer shares rst.
//   Widths:
//   - Counter is $clog2(WIDTH+1) bits and never exceeds WIDTH.
//   - ptr wraps from N_REQ-1 to 0.
//   Invariants:
//   - grant is $onehot0.
//   - busy == |grant.
//   - ser_last and ser_flush are never high together.
// TESTING
//   1 Single source: req[2]=1, 8 valid bits 1,0,1,1,0,0,1,0 -> grant=0100 one cycle later;
//     bits forwarded in order; ser_last on bit 8; grant=0 next cycle.
//   2 Round robin: req=1111 held for 4 frames -> grant order 0,1,2,3, each 8 bits long,
//     with one idle cycle between frames.
//   3 Gaps: granted source asserts bit_valid every other cycle -> 8 bits forwarded,
//     ser_last on the 8th valid bit; bits from other sources are never seen on ser_data.
//   4 Abort: source 1 drops req after 3 bits -> ser_flush=1 for one cycle, ser_valid=0
//     that cycle; the next grant goes to source 2 if it is requesting.
//   5 Edge: req drops in the same cycle as the 8th bit -> ser_last=1 and ser_flush=0.
//   6 Reset mid-frame: rst after 5 bits -> all outputs 0 next cycle; the next frame
//     is granted to source 0 first.

Source files
------------

// File: rtl/serial_link_arbiter.sv
// serial_link_arbiter
// Round-robin arbiter that shares one serial deserializer among N_REQ serial
// sources. The channel is granted for one frame of WIDTH bits. The granted
// source's bit stream is forwarded with zero latency and tagged with its index.
// If the owner drops its request mid-frame, the frame is aborted and the
// deserializer is flushed.
module serial_link_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         bit_valid,
  input  logic [N_REQ-1:0]         bit_data,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] owner_id,
  output logic                     busy,
  output logic                     ser_valid,
  output logic                     ser_data,
  output logic                     ser_last,
  output logic                     ser_flush
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [IDW-1:0]   pick_idx;
  logic             pick_found;
  logic [IDW-1:0]   next_ptr;
  logic             is_busy;
  logic             last_bit;
  logic             completing;
  logic             abort;

  // Round-robin search: first requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin : rr_search
    int unsigned idx;
    // NOTE: every signal gets a default before any branch, so no latch can be inferred.
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = IDW'(idx);
      end
    end
  end

  // Forwarding path: zero-latency mux from the owner, with abort/last detection.
  always_comb begin
    is_busy    = (state_q == BUSY);
    last_bit   = (cnt_q == CW'(WIDTH - 1));
    // A request dropped together with the final bit still completes the frame.
    completing = is_busy && bit_valid[owner_q] && last_bit;
    abort      = is_busy && !req[owner_q] && !completing;
    ser_valid  = is_busy && bit_valid[owner_q] && !abort;
    ser_data   = is_busy && bit_data[owner_q];
    ser_last   = ser_valid && last_bit;
    ser_flush  = abort;
    next_ptr   = (owner_q == IDW'(N_REQ - 1)) ? '0 : owner_q + IDW'(1);
  end

  // Next-state logic: grant on a pending request, release on frame end or abort.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          grant_d = N_REQ'(1) << pick_idx;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (ser_last || abort) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
          ptr_d   = next_ptr;
        end else if (ser_valid) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; reset never produces a flush pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant    = grant_q;
  assign owner_id = owner_q;
  assign busy     = is_busy;

endmodule

// File: tb/tb_serial_link_arbiter.sv
// Directed, table-driven bench for serial_link_arbiter (N_REQ=4, WIDTH=8).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_serial_link_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req, bit_valid, bit_data;
  logic [3:0] grant;
  logic [1:0] owner_id;
  logic       busy, ser_valid, ser_data, ser_last, ser_flush;

  int n_tests = 0;
  int n_fail  = 0;

  serial_link_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req(req), .bit_valid(bit_valid), .bit_data(bit_data),
    .grant(grant), .owner_id(owner_id), .busy(busy), .ser_valid(ser_valid),
    .ser_data(ser_data), .ser_last(ser_last), .ser_flush(ser_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req, bv, bd;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy, sv, sd, sl, sf;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(input logic r, input logic [3:0] rq, bv, bd,
                              input logic [3:0] g, input logic [1:0] o,
                              input logic b, sv, sd, sl, sf);
    vec_t v;
    v.rst = r; v.req = rq; v.bv = bv; v.bd = bd;
    v.grant = g; v.owner = o; v.busy = b;
    v.sv = sv; v.sd = sd; v.sl = sl; v.sf = sf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, then compare all outputs and the invariants.
  task automatic cyc(input string name, input logic r, input logic [3:0] rq, bv, bd,
                     input logic [3:0] e_grant, input logic [1:0] e_owner,
                     input logic e_busy, e_sv, e_sd, e_sl, e_sf);
    logic [10:0] act, exp;
    @(negedge clk);
    rst = r; req = rq; bit_valid = bv; bit_data = bd;
    #1;
    act = {grant, busy ? owner_id : 2'b00, busy, ser_valid, ser_data, ser_last, ser_flush};
    exp = {e_grant, e_busy ? e_owner : 2'b00, e_busy, e_sv, e_sd, e_sl, e_sf};
    check(name, 32'(act), 32'(exp));
    check({name, "_inv"},
          {29'd0, $onehot0(grant), busy == (|grant), !(ser_last && ser_flush)}, 32'd7);
  endtask

  task automatic idle_cyc(input string name, input logic [3:0] rq);
    cyc(name, 1'b0, rq, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // A forwarded bit from src; the other sources carry the inverted bit as noise.
  task automatic bit_cyc(input string name, input logic r, input logic [3:0] rq,
                         input logic [1:0] src, input logic b, input logic e_sl);
    logic [3:0] bd;
    bd = {4{~b}};
    bd[src] = b;
    cyc(name, r, rq, 4'b1111, bd, 4'b0001 << src, src, 1'b1, 1'b1, b, e_sl, 1'b0);
  endtask

  // Idle/arbitration cycle followed by a complete 8-bit frame from src.
  task automatic frame(input string name, input logic [1:0] src, input logic [3:0] rq,
                       input logic [7:0] bits);
    idle_cyc({name, "_arb"}, rq);
    for (int k = 0; k < 8; k++)
      bit_cyc($sformatf("%s_b%0d", name, k), 1'b0, rq, src, bits[7-k], k == 7);
  endtask

  initial begin
    logic [7:0] bits1;
    logic [7:0] bits3;
    logic [3:0] bd;
    logic       b;
    int         nv;

    rst = 1'b1; req = '0; bit_valid = '0; bit_data = '0;

    // Test 1: single source 2, bits 1,0,1,1,0,0,1,0; other sources carry inverted noise.
    bits1  = 8'b10110010;
    tbl[0] = mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      b  = bits1[7-k];
      bd = {4{~b}};
      bd[2] = b;
      tbl[2+k] = mk(0, 4'b0100, 4'b1111, bd, 4'b0100, 2'd2, 1, 1, b, k == 7, 0);
    end
    tbl[10] = mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < 11; i++)
      cyc($sformatf("t1_row%0d", i), tbl[i].rst, tbl[i].req, tbl[i].bv, tbl[i].bd,
          tbl[i].grant, tbl[i].owner, tbl[i].busy, tbl[i].sv, tbl[i].sd, tbl[i].sl, tbl[i].sf);

    // Test 2: reset pointer, then all four request -> frames 0,1,2,3 with one idle gap.
    cyc("t2_rst", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, 0, 0, 0);
    frame("t2_f0", 2'd0, 4'b1111, 8'hC3);
    frame("t2_f1", 2'd1, 4'b1111, 8'h5A);
    frame("t2_f2", 2'd2, 4'b1111, 8'h0F);
    frame("t2_f3", 2'd3, 4'b1111, 8'h96);

    // Test 3: source 1 sends valid bits every other cycle; others always valid with noise.
    bits3 = 8'b11001010;
    idle_cyc("t3_arb", 4'b0010);
    nv = 0;
    for (int k = 0; k < 15; k++) begin
      if (k % 2 == 0) begin
        b  = bits3[7-nv];
        bd = {4{~b}};
        bd[1] = b;
        cyc($sformatf("t3_v%0d", nv), 1'b0, 4'b0010, 4'b1111, bd,
            4'b0010, 2'd1, 1, 1, b, nv == 7, 0);
        nv++;
      end else begin
        cyc($sformatf("t3_gap%0d", k), 1'b0, 4'b0010, 4'b1101, 4'b1101,
            4'b0010, 2'd1, 1, 0, 0, 0, 0);
      end
    end
    idle_cyc("t3_end", 4'b0000);

    // Test 4: source 1 aborts after 3 bits; source 2 is granted next, then aborts at count 0.
    cyc("t4_rst", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, 0, 0, 0);
    idle_cyc("t4_arb", 4'b0110);
    for (int k = 0; k < 3; k++)
      bit_cyc($sformatf("t4_b%0d", k), 1'b0, 4'b0110, 2'd1, k[0], 1'b0);
    cyc("t4_abort", 1'b0, 4'b0100, 4'b1111, 4'b1111, 4'b0010, 2'd1, 1, 0, 1, 0, 1);
    idle_cyc("t4_gap", 4'b0100);
    cyc("t4_abort0", 1'b0, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 0, 0, 0, 1);
    idle_cyc("t4_end", 4'b0000);

    // Test 5: source 3 drops req together with its 8th bit -> completes, no flush.
    idle_cyc("t5_arb", 4'b1000);
    for (int k = 0; k < 7; k++)
      bit_cyc($sformatf("t5_b%0d", k), 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    bit_cyc("t5_last", 1'b0, 4'b0000, 2'd3, 1'b0, 1'b1);
    idle_cyc("t5_end", 4'b0000);

    // Test 6: frame 0 moves ptr to 1; source 2 is reset after 5 bits; ptr restarts at 0.
    frame("t6_f0", 2'd0, 4'b0001, 8'hA5);
    idle_cyc("t6_arb", 4'b0100);
    for (int k = 0; k < 5; k++)
      bit_cyc($sformatf("t6_b%0d", k), 1'b0, 4'b0100, 2'd2, k[0], 1'b0);
    bit_cyc("t6_rst", 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0);
    cyc("t6_post", 1'b0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, 0, 0, 0);
    cyc("t6_grant0", 1'b0, 4'b0101, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1, 0, 0, 0, 0);
    cyc("t6_abort", 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1, 0, 0, 0, 1);
    idle_cyc("t6_end", 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
